// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Two-port round-robin arbiter for a 4-bit x 256-nibble asynchronous RAM
//   on a shared, bidirectional nibble bus. Each granted access runs
//   IDLE -> SETUP -> STROBE (STROBE_CYCLES cycles) -> HOLD -> IDLE.
//   The RAM address, both strobes, bus_out and bus_oe all come straight
//   from flops, so they never glitch.
//
// Parameters
//   STROBE_CYCLES      cycles the active-low strobe is held low (1..4)
//
// Ports
//   clk, reset         clock; asynchronous active-high reset
//   req0/req1          request per port, held high until its ack
//   we0/we1            1 = write, 0 = read
//   addr0/addr1        8-bit nibble address
//   wdata0/wdata1      4-bit write data
//   ack0/ack1          one-cycle completion pulse
//   rdata0/rdata1      last read result for each port
//   mem_addr           RAM address
//   mem_nread_enable   active-low RAM read strobe
//   mem_nwrite_enable  active-low RAM write strobe
//   bus_out, bus_oe    data and drive enable toward the shared bus
//   bus_in             resolved value of the shared bus
module ram_arbiter #(
    parameter int STROBE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic       we0,
    input  logic       we1,
    input  logic [7:0] addr0,
    input  logic [7:0] addr1,
    input  logic [3:0] wdata0,
    input  logic [3:0] wdata1,
    output logic       ack0,
    output logic       ack1,
    output logic [3:0] rdata0,
    output logic [3:0] rdata1,
    output logic [7:0] mem_addr,
    output logic       mem_nread_enable,
    output logic       mem_nwrite_enable,
    output logic [3:0] bus_out,
    output logic       bus_oe,
    input  logic [3:0] bus_in
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD
    } state_t;

    localparam logic [1:0] CNT_LAST = 2'(STROBE_CYCLES - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_cnt;
    logic       r_last_gnt;   // port granted most recently
    logic       r_gnt;        // port owning the current transaction
    logic       r_we;         // direction of the current transaction

    logic       w_grant;
    logic       w_sel;
    logic       w_strobe_last;
    logic       w_gnt_nxt;
    logic       w_we_nxt;
    logic [7:0] w_addr_nxt;
    logic [3:0] w_bout_nxt;
    logic       w_nread_d;
    logic       w_nwrite_d;
    logic       w_oe_d;
    logic       w_ack0_d;
    logic       w_ack1_d;

    // Requests are only looked at in IDLE. On a tie the port that was not
    // granted last time wins.
    assign w_grant       = (r_state == S_IDLE) && (req0 || req1);
    assign w_sel         = (req0 && req1) ? ~r_last_gnt : req1;
    assign w_strobe_last = (r_state == S_STROBE) && (r_cnt == CNT_LAST);

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Strobe-length counter, parked at zero outside STROBE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= 2'd0;
        end else if (r_state == S_STROBE) begin
            r_cnt <= r_cnt + 2'd1;
        end else begin
            r_cnt <= 2'd0;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_grant) w_state_nxt = S_SETUP;
            S_SETUP:  w_state_nxt = S_STROBE;
            S_STROBE: if (w_strobe_last) w_state_nxt = S_HOLD;
            S_HOLD:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    // Computes the value every registered output takes at the next edge,
    // from the next state and the transaction fields as they will be
    // latched. Registering these keeps the RAM-side pins glitch-free.
    always_comb begin
        w_gnt_nxt  = r_gnt;
        w_we_nxt   = r_we;
        w_addr_nxt = mem_addr;
        w_bout_nxt = bus_out;
        if (w_grant) begin
            w_gnt_nxt  = w_sel;
            w_we_nxt   = w_sel ? we1   : we0;
            w_addr_nxt = w_sel ? addr1 : addr0;
            // bus_out only moves for writes; reads leave it as it was.
            if (w_sel ? we1 : we0) begin
                w_bout_nxt = w_sel ? wdata1 : wdata0;
            end
        end
        w_nread_d  = !((w_state_nxt == S_STROBE) && !w_we_nxt);
        w_nwrite_d = !((w_state_nxt == S_STROBE) &&  w_we_nxt);
        w_oe_d     = (w_state_nxt != S_IDLE) && w_we_nxt;
        w_ack0_d   = (w_state_nxt == S_HOLD) && !w_gnt_nxt;
        w_ack1_d   = (w_state_nxt == S_HOLD) &&  w_gnt_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_addr          <= 8'h00;
            bus_out           <= 4'h0;
            mem_nread_enable  <= 1'b1;
            mem_nwrite_enable <= 1'b1;
            bus_oe            <= 1'b0;
            ack0              <= 1'b0;
            ack1              <= 1'b0;
            r_gnt             <= 1'b0;
            r_we              <= 1'b0;
            r_last_gnt        <= 1'b1;   // port 0 wins the first tie
        end else begin
            mem_addr          <= w_addr_nxt;
            bus_out           <= w_bout_nxt;
            mem_nread_enable  <= w_nread_d;
            mem_nwrite_enable <= w_nwrite_d;
            bus_oe            <= w_oe_d;
            ack0              <= w_ack0_d;
            ack1              <= w_ack1_d;
            r_gnt             <= w_gnt_nxt;
            r_we              <= w_we_nxt;
            if (w_grant) begin
                r_last_gnt <= w_sel;
            end
        end
    end

    // Read data is taken from the bus on the edge that ends the last strobe
    // cycle, while the RAM is still driving it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata0 <= 4'h0;
            rdata1 <= 4'h0;
        end else if (w_strobe_last && !r_we) begin
            if (r_gnt) begin
                rdata1 <= bus_in;
            end else begin
                rdata0 <= bus_in;
            end
        end
    end

endmodule
